// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-port request arbiter in front of an SDRAM controller.
// Work is served in fixed 8-clock slots. Refresh has the highest priority,
// then port 0 (CPU), then port 1 (loader/DMA). All command outputs are registered.
`timescale 1ns/1ps
module sdram_arbiter #(
  parameter int REFRESH_CYCLES = 250
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ready,
  // port 0 (CPU)
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [21:0] p0_addr,
  input  logic [15:0] p0_din,
  input  logic [1:0]  p0_ds,
  output logic        p0_busy,
  output logic        p0_ack,
  output logic [15:0] p0_dout,
  // port 1 (loader/DMA)
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [21:0] p1_addr,
  input  logic [15:0] p1_din,
  input  logic [1:0]  p1_ds,
  output logic        p1_busy,
  output logic        p1_ack,
  output logic [15:0] p1_dout,
  // controller command bus
  output logic        cs,
  output logic        we,
  output logic [21:0] addr,
  output logic [15:0] din,
  output logic [1:0]  ds,
  output logic        refresh,
  input  logic [15:0] dout
);

  localparam int TW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(REFRESH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, REFRESH} state_t;

  state_t        state;
  logic [2:0]    slot;
  logic          gnt_p1;          // port owning the current ACCESS slot
  logic [TW-1:0] timer;
  logic          refresh_pending;

  logic          p0_we_q, p1_we_q;
  logic [21:0]   p0_addr_q, p1_addr_q;
  logic [15:0]   p0_din_q, p1_din_q;
  logic [1:0]    p0_ds_q, p1_ds_q;

  logic slot_end, done_p0, done_p1, p0_wait, p1_wait;
  logic can_start, start_ref, start_p0, start_p1, wrap;

  // Slot-boundary decisions: who completes now and who starts next.
  // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    slot_end  = (state != IDLE) && (slot == 3'd7);
    done_p0   = slot_end && (state == ACCESS) && !gnt_p1;
    done_p1   = slot_end && (state == ACCESS) && gnt_p1;
    // a port already in flight is not eligible for the next slot
    p0_wait   = p0_busy && !((state == ACCESS) && !gnt_p1);
    p1_wait   = p1_busy && !((state == ACCESS) && gnt_p1);
    can_start = ready && ((state == IDLE) || slot_end);
    start_ref = can_start && refresh_pending;
    start_p0  = can_start && !refresh_pending && p0_wait;
    start_p1  = can_start && !refresh_pending && !p0_wait && p1_wait;
    wrap      = (timer == TIMER_LAST);
  end

  // Refresh timer and the single pending-refresh flag.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer           <= '0;
      refresh_pending <= 1'b0;
    end else begin
      timer <= wrap ? '0 : timer + TW'(1);
      if (wrap)
        refresh_pending <= 1'b1;
      else if (start_ref)
        refresh_pending <= 1'b0;
    end
  end

  // Port 0 request latch and completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p0_busy   <= 1'b0;
      p0_ack    <= 1'b0;
      p0_dout   <= '0;
      p0_we_q   <= 1'b0;
      p0_addr_q <= '0;
      p0_din_q  <= '0;
      p0_ds_q   <= '0;
    end else begin
      p0_ack <= 1'b0;
      if (p0_req && !p0_busy) begin
        p0_busy   <= 1'b1;
        p0_we_q   <= p0_we;
        p0_addr_q <= p0_addr;
        p0_din_q  <= p0_din;
        p0_ds_q   <= p0_ds;
      end else if (done_p0) begin
        p0_busy <= 1'b0;
        p0_ack  <= 1'b1;
        if (!p0_we_q)
          p0_dout <= dout;
      end
    end
  end

  // Port 1 request latch and completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p1_busy   <= 1'b0;
      p1_ack    <= 1'b0;
      p1_dout   <= '0;
      p1_we_q   <= 1'b0;
      p1_addr_q <= '0;
      p1_din_q  <= '0;
      p1_ds_q   <= '0;
    end else begin
      p1_ack <= 1'b0;
      if (p1_req && !p1_busy) begin
        p1_busy   <= 1'b1;
        p1_we_q   <= p1_we;
        p1_addr_q <= p1_addr;
        p1_din_q  <= p1_din;
        p1_ds_q   <= p1_ds;
      end else if (done_p1) begin
        p1_busy <= 1'b0;
        p1_ack  <= 1'b1;
        if (!p1_we_q)
          p1_dout <= dout;
      end
    end
  end

  // Slot engine: state, slot counter and registered command bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      slot    <= '0;
      gnt_p1  <= 1'b0;
      cs      <= 1'b0;
      refresh <= 1'b0;
      we      <= 1'b0;
      addr    <= '0;
      din     <= '0;
      ds      <= '0;
    end else if (start_ref) begin
      state   <= REFRESH;
      slot    <= '0;
      cs      <= 1'b0;
      refresh <= 1'b1;
      we      <= 1'b0;
    end else if (start_p0 || start_p1) begin
      state   <= ACCESS;
      slot    <= '0;
      gnt_p1  <= start_p1;
      cs      <= 1'b1;
      refresh <= 1'b0;
      we      <= start_p1 ? p1_we_q   : p0_we_q;
      addr    <= start_p1 ? p1_addr_q : p0_addr_q;
      din     <= start_p1 ? p1_din_q  : p0_din_q;
      ds      <= start_p1 ? p1_ds_q   : p0_ds_q;
    end else if (state != IDLE) begin
      if (slot == 3'd7) begin
        state   <= IDLE;
        slot    <= '0;
        cs      <= 1'b0;
        refresh <= 1'b0;
      end else begin
        slot    <= slot + 3'd1;
        // cs covers cycles 0-5, refresh cycles 0-3; the tail is always low
        cs      <= (state == ACCESS)  && (slot < 3'd5);
        refresh <= (state == REFRESH) && (slot < 3'd3);
      end
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed testbench for sdram_arbiter. Two instances share the stimulus:
// dut uses the default refresh interval (no refresh within a test), dut_r
// uses REFRESH_CYCLES=16 for the refresh scenarios. Edge count e is the
// number of clock edges since reset release; outputs are read 1 ns after it.
`timescale 1ns/1ps
module tb_sdram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ready = 1'b0;
  logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [21:0] p0_addr = '0, p1_addr = '0;
  logic [15:0] p0_din = '0, p1_din = '0, ctl_dout = '0;
  logic [1:0]  p0_ds = '0, p1_ds = '0;

  logic        p0_busy, p0_ack, p1_busy, p1_ack, cs, we, refresh;
  logic [15:0] p0_dout, p1_dout, din;
  logic [21:0] addr;
  logic [1:0]  ds;

  logic        r_p0_busy, r_p0_ack, r_p1_busy, r_p1_ack, r_cs, r_we, r_refresh;
  logic [15:0] r_p0_dout, r_p1_dout, r_din;
  logic [21:0] r_addr;
  logic [1:0]  r_ds;

  int checks = 0;
  int errors = 0;
  int e = 0;

  always #5 clk = ~clk;

  sdram_arbiter dut (
    .clk(clk), .reset_n(reset_n), .ready(ready),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_din(p0_din), .p0_ds(p0_ds),
    .p0_busy(p0_busy), .p0_ack(p0_ack), .p0_dout(p0_dout),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_din(p1_din), .p1_ds(p1_ds),
    .p1_busy(p1_busy), .p1_ack(p1_ack), .p1_dout(p1_dout),
    .cs(cs), .we(we), .addr(addr), .din(din), .ds(ds), .refresh(refresh), .dout(ctl_dout)
  );

  sdram_arbiter #(.REFRESH_CYCLES(16)) dut_r (
    .clk(clk), .reset_n(reset_n), .ready(ready),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_din(p0_din), .p0_ds(p0_ds),
    .p0_busy(r_p0_busy), .p0_ack(r_p0_ack), .p0_dout(r_p0_dout),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_din(p1_din), .p1_ds(p1_ds),
    .p1_busy(r_p1_busy), .p1_ack(r_p1_ack), .p1_dout(r_p1_dout),
    .cs(r_cs), .we(r_we), .addr(r_addr), .din(r_din), .ds(r_ds), .refresh(r_refresh), .dout(ctl_dout)
  );

  task automatic tick;
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic do_reset(input logic rdy);
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_din = '0; p0_ds = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_din = '0; p1_ds = '0;
    ctl_dout = 16'hDEAD;
    ready = rdy;
    reset_n = 0;
    tick;
    tick;
    reset_n = 1;
    e = 0;
  endtask

  task automatic test_reset;
    reset_n = 0;
    tick;
    tick;
    checks++;
    if ({cs, refresh, we, addr, din, ds, p0_busy, p0_ack, p0_dout, p1_busy, p1_ack, p1_dout} !== '0) begin
      errors++;
      $display("FAIL reset_dut got cs=%b ref=%b we=%b addr=%h din=%h ds=%b b0=%b a0=%b d0=%h b1=%b a1=%b d1=%h exp all 0",
               cs, refresh, we, addr, din, ds, p0_busy, p0_ack, p0_dout, p1_busy, p1_ack, p1_dout);
    end
    checks++;
    if ({r_cs, r_refresh, r_we, r_addr, r_din, r_ds, r_p0_busy, r_p0_ack, r_p0_dout, r_p1_busy, r_p1_ack, r_p1_dout} !== '0) begin
      errors++;
      $display("FAIL reset_dut_r got nonzero outputs cs=%b ref=%b addr=%h exp all 0", r_cs, r_refresh, r_addr);
    end
  endtask

  // p0 read of 0x000123, data 0xBEEF in cycle 7; new strobe in the ack cycle
  task automatic test_read;
    int busy_n = 0;
    int ack_n = 0;
    logic exp_cs;
    do_reset(1);
    p0_req = 1; p0_we = 0; p0_addr = 22'h000123;
    for (int k = 1; k <= 14; k++) begin
      tick;
      p0_req = 0;
      ctl_dout = (e == 9) ? 16'hBEEF : 16'hDEAD;
      if (e <= 10 && p0_busy) busy_n++;
      if (e <= 11 && p0_ack) ack_n++;
      exp_cs = (e >= 2 && e <= 7) || (e >= 12);
      checks++;
      if (cs !== exp_cs) begin
        errors++;
        $display("FAIL read_cs e=%0d got %b exp %b", e, cs, exp_cs);
      end
      if (e >= 2 && e <= 9) begin
        checks++;
        if ({we, addr} !== {1'b0, 22'h000123}) begin
          errors++;
          $display("FAIL read_cmd e=%0d got we=%b addr=%h exp we=0 addr=000123", e, we, addr);
        end
      end
      if (e == 10) begin
        checks++;
        if ({p0_ack, p0_busy, p0_dout} !== {1'b1, 1'b0, 16'hBEEF}) begin
          errors++;
          $display("FAIL read_done got ack=%b busy=%b dout=%h exp ack=1 busy=0 dout=beef", p0_ack, p0_busy, p0_dout);
        end
        p0_req = 1; p0_addr = 22'h000456;
      end
      if (e == 12) begin
        checks++;
        if (addr !== 22'h000456) begin
          errors++;
          $display("FAIL read_ack_cycle_req got addr=%h exp 000456", addr);
        end
      end
    end
    checks++;
    if (busy_n != 9) begin
      errors++;
      $display("FAIL read_busy_len got %0d exp 9", busy_n);
    end
    checks++;
    if (ack_n != 1) begin
      errors++;
      $display("FAIL read_ack_count got %0d exp 1", ack_n);
    end
  endtask

  // p0 and p1 writes strobed together: p0 slot, then p1 slot 8 clocks later
  task automatic test_back_to_back;
    logic exp_cs;
    do_reset(1);
    p0_req = 1; p0_we = 1; p0_addr = 22'h000010; p0_din = 16'h1234; p0_ds = 2'b01;
    p1_req = 1; p1_we = 1; p1_addr = 22'h000020; p1_din = 16'h5678; p1_ds = 2'b10;
    for (int k = 1; k <= 20; k++) begin
      tick;
      p0_req = 0; p1_req = 0;
      exp_cs = (e >= 2 && e <= 7) || (e >= 10 && e <= 15);
      checks++;
      if (cs !== exp_cs) begin
        errors++;
        $display("FAIL b2b_cs e=%0d got %b exp %b", e, cs, exp_cs);
      end
      if (e >= 2 && e <= 9) begin
        checks++;
        if ({we, addr, din, ds} !== {1'b1, 22'h000010, 16'h1234, 2'b01}) begin
          errors++;
          $display("FAIL b2b_p0_cmd e=%0d got we=%b addr=%h din=%h ds=%b", e, we, addr, din, ds);
        end
      end
      if (e >= 10 && e <= 17) begin
        checks++;
        if ({we, addr, din, ds} !== {1'b1, 22'h000020, 16'h5678, 2'b10}) begin
          errors++;
          $display("FAIL b2b_p1_cmd e=%0d got we=%b addr=%h din=%h ds=%b", e, we, addr, din, ds);
        end
      end
      checks++;
      if ({p0_ack, p1_ack} !== {(e == 10), (e == 18)}) begin
        errors++;
        $display("FAIL b2b_ack e=%0d got p0=%b p1=%b exp p0=%b p1=%b", e, p0_ack, p1_ack, (e == 10), (e == 18));
      end
    end
    checks++;
    if ({p0_dout, p1_dout} !== 32'h0) begin
      errors++;
      $display("FAIL b2b_write_dout got p0=%h p1=%h exp 0000 0000", p0_dout, p1_dout);
    end
  endtask

  // a second strobe while busy is ignored
  task automatic test_busy_ignore;
    logic exp_cs;
    do_reset(1);
    p0_req = 1; p0_we = 0; p0_addr = 22'h000AAA;
    for (int k = 1; k <= 14; k++) begin
      tick;
      if (e == 1) begin
        p0_req = 1; p0_addr = 22'h000BBB;
      end else begin
        p0_req = 0;
      end
      exp_cs = (e >= 2 && e <= 7);
      checks++;
      if ({cs, p0_ack, p0_busy} !== {exp_cs, (e == 10), (e <= 9)}) begin
        errors++;
        $display("FAIL busy_ign e=%0d got cs=%b ack=%b busy=%b exp cs=%b ack=%b busy=%b",
                 e, cs, p0_ack, p0_busy, exp_cs, (e == 10), (e <= 9));
      end
      if (e >= 2 && e <= 9) begin
        checks++;
        if (addr !== 22'h000AAA) begin
          errors++;
          $display("FAIL busy_ign_addr e=%0d got %h exp 000aaa", e, addr);
        end
      end
    end
  endtask

  // request while ready=0; ready rises at e=20 and drops mid-slot at e=23
  task automatic test_ready;
    logic exp_cs;
    do_reset(0);
    p0_req = 1; p0_we = 0; p0_addr = 22'h0ABCDE;
    for (int k = 1; k <= 32; k++) begin
      tick;
      p0_req = 0;
      if (e == 20) ready = 1;
      if (e == 23) ready = 0;
      ctl_dout = (e == 28) ? 16'h0F0F : 16'hDEAD;
      exp_cs = (e >= 21 && e <= 26);
      checks++;
      if ({cs, p0_ack, p0_busy} !== {exp_cs, (e == 29), (e <= 28)}) begin
        errors++;
        $display("FAIL ready e=%0d got cs=%b ack=%b busy=%b exp cs=%b ack=%b busy=%b",
                 e, cs, p0_ack, p0_busy, exp_cs, (e == 29), (e <= 28));
      end
      if (e == 29) begin
        checks++;
        if (p0_dout !== 16'h0F0F) begin
          errors++;
          $display("FAIL ready_dout got %h exp 0f0f", p0_dout);
        end
      end
    end
  endtask

  // idle refresh cadence with REFRESH_CYCLES=16
  task automatic test_refresh;
    logic exp_r;
    do_reset(1);
    for (int k = 1; k <= 40; k++) begin
      tick;
      exp_r = (e >= 17 && e <= 20) || (e >= 33 && e <= 36);
      checks++;
      if ({r_refresh, r_cs, refresh} !== {exp_r, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL refresh e=%0d got ref=%b cs=%b ref250=%b exp ref=%b cs=0 ref250=0",
                 e, r_refresh, r_cs, refresh, exp_r);
      end
    end
  endtask

  // p1 strobe on the same edge as a timer wrap: refresh slot, then p1 slot
  task automatic test_wrap_p1;
    logic exp_r, exp_cs;
    do_reset(1);
    for (int k = 1; k <= 36; k++) begin
      tick;
      if (e == 15) begin
        p1_req = 1; p1_we = 0; p1_addr = 22'h2AAAAA;
      end else begin
        p1_req = 0;
      end
      exp_r  = (e >= 17 && e <= 20) || (e >= 33 && e <= 36);
      exp_cs = (e >= 25 && e <= 30);
      checks++;
      if ({r_refresh, r_cs, r_p1_ack} !== {exp_r, exp_cs, (e == 33)}) begin
        errors++;
        $display("FAIL wrap_p1 e=%0d got ref=%b cs=%b ack=%b exp ref=%b cs=%b ack=%b",
                 e, r_refresh, r_cs, r_p1_ack, exp_r, exp_cs, (e == 33));
      end
      checks++;
      if ((r_refresh & r_cs) !== 1'b0) begin
        errors++;
        $display("FAIL wrap_overlap e=%0d got cs&refresh=%b exp 0", e, r_refresh & r_cs);
      end
      if (e == 16 || e == 25) begin
        checks++;
        if ({r_p1_busy, (e == 25) ? r_addr : 22'h2AAAAA} !== {1'b1, 22'h2AAAAA}) begin
          errors++;
          $display("FAIL wrap_p1_latch e=%0d got busy=%b addr=%h exp busy=1 addr=2aaaaa", e, r_p1_busy, r_addr);
        end
      end
    end
  endtask

  // reset pulsed during cycle 3 of an access
  task automatic test_reset_mid;
    do_reset(1);
    p0_req = 1; p0_we = 0; p0_addr = 22'h3FFFFF; p0_din = 16'hFFFF; p0_ds = 2'b11;
    for (int k = 1; k <= 5; k++) begin
      tick;
      p0_req = 0;
    end
    checks++;
    if ({cs, addr} !== {1'b1, 22'h3FFFFF}) begin
      errors++;
      $display("FAIL rstmid_pre got cs=%b addr=%h exp cs=1 addr=3fffff", cs, addr);
    end
    #2;
    reset_n = 0;
    #1;
    checks++;
    if ({cs, refresh, we, addr, din, ds, p0_busy, p0_ack, p0_dout, p1_busy, p1_ack} !== '0) begin
      errors++;
      $display("FAIL rstmid_async got cs=%b we=%b addr=%h din=%h ds=%b busy=%b exp all 0",
               cs, we, addr, din, ds, p0_busy);
    end
    tick;
    reset_n = 1;
    for (int k = 1; k <= 12; k++) begin
      tick;
      checks++;
      if ({cs, p0_ack, p0_busy} !== 3'b000) begin
        errors++;
        $display("FAIL rstmid_after k=%0d got cs=%b ack=%b busy=%b exp 000", k, cs, p0_ack, p0_busy);
      end
    end
  endtask

  initial begin
    test_reset;
    test_read;
    test_back_to_back;
    test_busy_ignore;
    test_ready;
    test_refresh;
    test_wrap_p1;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter REFRESH_CYCLES, default 250, clocks between refresh requests (7.8 us at 32 MHz).
REQ-002 clk  in  1  system clock, 32 MHz, same clock as the SDRAM controller.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 ready  in  1  controller initialised; no slot starts while low.
REQ-005 p0_req  in  1  port 0 (CPU) single-cycle request strobe.
REQ-006 p0_we, p0_addr[21:0], p0_din[15:0], p0_ds[1:0]  in  1/22/16/2  port 0 write flag, word address, write data, byte strobes (active-high), sampled with p0_req.
REQ-007 p0_busy  out  1  port 0 request pending or in flight.
REQ-008 p0_ack  out  1  one-cycle completion pulse.
REQ-009 p0_dout  out  16  read data, valid with p0_ack.
REQ-010 p1_req, p1_we, p1_addr, p1_din, p1_ds, p1_busy, p1_ack, p1_dout  same widths and meaning for port 1 (loader/DMA).
REQ-011 cs, we, addr[21:0], din[15:0], ds[1:0], refresh  out  1/1/22/16/2/1  registered controller command bus.
REQ-012 dout  in  16  controller read data.

Function
REQ-013 Port request latch: when p*_req=1 and p*_busy=0, the port's we/addr/din/ds SHALL be captured and p*_busy set on the next clock. A strobe while busy SHALL be ignored.
REQ-014 Refresh timer: counts 0..REFRESH_CYCLES-1 and wraps. At wrap it SHALL set refresh_pending; further wraps while pending leave it set, with no count kept.
REQ-015 Slot engine: a 3-bit slot counter; every access or refresh occupies exactly 8 clocks, numbered cycle 0-7.
REQ-016 States are IDLE, ACCESS and REFRESH. IDLE -> ACCESS/REFRESH happens only when ready=1 and work is pending; ACCESS/REFRESH -> IDLE happens after cycle 7.
REQ-017 Priority at slot start: refresh_pending, then port 0, then port 1. There is no fairness for port 1 beyond this order.
REQ-018 ACCESS: cs SHALL be 1 in cycles 0-5 and 0 in cycles 6-7. we/addr/din/ds SHALL hold the granted port's latched values for all 8 cycles.
REQ-019 REFRESH: refresh SHALL be 1 in cycles 0-3 and 0 in cycles 4-7. cs stays 0. refresh_pending clears in cycle 0.
REQ-020 cs and refresh SHALL never be 1 in the same cycle.
REQ-021 Every slot ends with at least 2 low cycles on cs/refresh, so the controller always sees a fresh rising edge while idle.
REQ-022 Completion: at the clock edge ending cycle 7 of an ACCESS slot:
- latch dout into p*_dout (reads only; writes leave p*_dout unchanged);
- pulse p*_ack for exactly one cycle;
- clear p*_busy.
REQ-023 Back-to-back: the next slot MAY start on the cycle immediately after cycle 7. Maximum throughput is one access per 8 clocks.
REQ-024 A port SHALL accept a new p*_req in the same cycle its p*_ack is high, since busy already reads 0 then.
REQ-025 A timer wrap in the same cycle as a port strobe SHALL register both; the next slot serves refresh first.
REQ-026 ready falling mid-slot SHALL NOT abort the slot. New slots wait for ready=1; pending requests are retained.

Reset
REQ-027 reset_n=0 SHALL immediately clear, asynchronously:
- cs, refresh, we, p0_busy, p1_busy, p0_ack, p1_ack, refresh_pending;
- state (to IDLE), slot counter and refresh timer (to 0).
REQ-028 On the same reset, addr, din, ds, p0_dout and p1_dout SHALL go to 0.
REQ-029 Reset asserted mid-slot SHALL drop the slot with no ack. After release the first refresh comes after REFRESH_CYCLES clocks.

Verification
REQ-030 ready=1, p0 read of addr 0x000123 with controller model returning 0xBEEF -> cs high cycles 0-5, addr=0x000123, we=0, p0_ack at cycle 8, p0_dout=0xBEEF, p0_busy high 9 cycles total.
REQ-031 p0 write (0x1234, ds=2'b01) and p1 write strobed in the same cycle -> p0 slot first, then p1 slot starting exactly 8 clocks later, and each ack fires once.
REQ-032 REFRESH_CYCLES=16 with no traffic -> refresh high 4 cycles every 16 clocks, cs stays 0.
REQ-033 Timer wrap coincident with a p1_req -> refresh slot, then p1 slot, with no overlap of cs and refresh.
REQ-034 p0_req while ready=0, then ready rises 20 clocks later -> no cs before ready; slot starts the cycle after ready=1.
REQ-035 reset_n pulsed low during cycle 3 of an access -> all outputs 0 within the same cycle; no ack after release; second strobe while busy is ignored (busy check).
